// File: rtl/mole_field_animator.sv
// mole_field_animator: per-hole pop-up FSMs with a registered mole sprite layer; define MOLE_HIT_FLASH_EN to enable the HIT flash state
module mole_field_animator #(
    parameter int          NUM_HOLES   = 5,
    parameter int          STEP_CYCLES = 500000,
    parameter int          LEVELS      = 4,
    parameter int          HOLD_TICKS  = 6,
    parameter int          HIT_TICKS   = 3,
    parameter int          MOLE_W      = 30,
    parameter int          MOLE_H      = 16,
    parameter logic [11:0] MOLE_COLOR  = 12'h642,
    parameter logic [11:0] EYE_COLOR   = 12'hFFF,
    parameter logic [11:0] HIT_COLOR   = 12'hF00,
    parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10*NUM_HOLES-1:0] hole_x_flat,
    input  logic [10*NUM_HOLES-1:0] hole_y_flat,
    input  logic                    spawn_valid,
    input  logic [2:0]              spawn_hole,
    output logic                    spawn_ready,
    input  logic                    whack_valid,
    input  logic [2:0]              whack_hole,
    output logic                    hit_pulse,
    output logic                    miss_pulse,
    output logic                    escape_pulse,
    output logic [7:0]              hit_count,
    output logic [NUM_HOLES-1:0]    active_mask,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    output logic                    pixel_on,
    output logic [11:0]             mole_color
);
    typedef enum logic [2:0] {S_IDLE, S_RISING, S_UP, S_SINKING, S_HIT} state_t;

    localparam int PW = $clog2(STEP_CYCLES);
    localparam int CW = $clog2(HOLD_TICKS + HIT_TICKS + 1);

    state_t               r_state   [NUM_HOLES];
    state_t               w_state_n [NUM_HOLES];
    logic [2:0]           r_level   [NUM_HOLES];
    logic [2:0]           w_level_n [NUM_HOLES];
    logic [CW-1:0]        r_cnt     [NUM_HOLES];
    logic [CW-1:0]        w_cnt_n   [NUM_HOLES];
    logic [9:0]           w_rx      [NUM_HOLES];
    logic [9:0]           w_ry      [NUM_HOLES];
    logic [9:0]           w_thr     [NUM_HOLES];
    logic [NUM_HOLES-1:0] w_box;
    logic [NUM_HOLES-1:0] w_eye;
    logic [NUM_HOLES-1:0] w_body;
    logic [PW-1:0]        r_pre;
    logic                 w_tick;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_esc;
    logic                 w_on;
    logic [11:0]          w_col;

    assign w_tick = r_pre == PW'(STEP_CYCLES - 1);

    // shared prescaler, event strobes, saturating hit counter and hole state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre        <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            escape_pulse <= 1'b0;
            hit_count    <= '0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                r_state[i] <= S_IDLE;
                r_level[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            hit_pulse    <= w_hit;
            miss_pulse   <= w_miss;
            escape_pulse <= w_esc;
            hit_count    <= hit_count + 8'(w_hit && hit_count != 8'hFF);
            for (int i = 0; i < NUM_HOLES; i++) begin
                r_state[i] <= w_state_n[i];
                r_level[i] <= w_level_n[i];
                r_cnt[i]   <= w_cnt_n[i];
            end
        end
    end

    // spawn acceptance, whack resolution and tick-driven animation; spawn beats whack beats tick
    always_comb begin
        spawn_ready = 1'b0;
        w_hit       = 1'b0;
        w_esc       = 1'b0;
        for (int i = 0; i < NUM_HOLES; i++)
            spawn_ready = spawn_ready | (spawn_hole == 3'(i) && r_state[i] == S_IDLE);
        for (int i = 0; i < NUM_HOLES; i++) begin
            w_state_n[i] = r_state[i];
            w_level_n[i] = r_level[i];
            w_cnt_n[i]   = r_cnt[i];
            if (spawn_valid && spawn_hole == 3'(i) && r_state[i] == S_IDLE) begin
                w_state_n[i] = S_RISING;
                w_level_n[i] = '0;
            end else if (whack_valid && whack_hole == 3'(i) && r_state[i] != S_IDLE && r_state[i] != S_HIT) begin
                w_hit = 1'b1;
`ifdef MOLE_HIT_FLASH_EN
                w_state_n[i] = S_HIT;
                w_cnt_n[i]   = '0;
`else
                w_state_n[i] = S_IDLE;
                w_level_n[i] = '0;
`endif
            end else if (w_tick) begin
                case (r_state[i])
                    S_RISING: begin
                        w_state_n[i] = r_level[i] == 3'(LEVELS - 1) ? S_UP : S_RISING;
                        w_level_n[i] = r_level[i] == 3'(LEVELS - 1) ? r_level[i] : r_level[i] + 3'd1;
                        w_cnt_n[i]   = '0;
                    end
                    S_UP: begin
                        w_state_n[i] = r_cnt[i] == CW'(HOLD_TICKS - 1) ? S_SINKING : S_UP;
                        w_cnt_n[i]   = r_cnt[i] + 1'b1;
                    end
                    S_SINKING: begin
                        w_state_n[i] = r_level[i] == 3'd0 ? S_IDLE : S_SINKING;
                        w_level_n[i] = r_level[i] == 3'd0 ? 3'd0 : r_level[i] - 3'd1;
                        w_esc        = w_esc | (r_level[i] == 3'd0);
                    end
                    S_HIT: begin
                        w_state_n[i] = r_cnt[i] == CW'(HIT_TICKS - 1) ? S_IDLE : S_HIT;
                        w_level_n[i] = r_cnt[i] == CW'(HIT_TICKS - 1) ? 3'd0 : r_level[i];
                        w_cnt_n[i]   = r_cnt[i] + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        w_miss = whack_valid && !w_hit;
    end

    // a hole is active whenever it is not idle
    always_comb begin
        active_mask = '0;
        for (int i = 0; i < NUM_HOLES; i++)
            active_mask[i] = r_state[i] != S_IDLE;
    end

    for (genvar h = 0; h < NUM_HOLES; h++) begin : g_hole
        assign w_rx[h]   = x - hole_x_flat[10*h +: 10] + 10'(MOLE_W / 2);
        assign w_ry[h]   = y - hole_y_flat[10*h +: 10] + 10'(MOLE_H / 2);
        assign w_thr[h]  = 10'(MOLE_H - ((int'(r_level[h]) + 1) * MOLE_H) / LEVELS);
        assign w_box[h]  = w_rx[h] < 10'(MOLE_W) && w_ry[h] < 10'(MOLE_H);
        assign w_body[h] = w_rx[h] >= 10'd4 && w_rx[h] < 10'(MOLE_W - 4);
        assign w_eye[h]  = w_ry[h] >= 10'd6 && w_ry[h] <= 10'd8 &&
                           ((w_rx[h] >= 10'd8 && w_rx[h] <= 10'd10) ||
                            (w_rx[h] >= 10'(MOLE_W - 10) && w_rx[h] <= 10'(MOLE_W - 8)));
    end

    // sprite selection; scanning downward lets the lowest hole index win on overlap
    always_comb begin
        w_on  = 1'b0;
        w_col = TRANSPARENT;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (w_box[i] && r_state[i] == S_HIT) begin
                w_on  = 1'b1;
                w_col = HIT_COLOR;
            end else if (w_box[i] && r_state[i] == S_UP && w_body[i]) begin
                w_on  = 1'b1;
                w_col = w_eye[i] ? EYE_COLOR : MOLE_COLOR;
            end else if (w_box[i] && (r_state[i] == S_RISING || r_state[i] == S_SINKING) && w_ry[i] >= w_thr[i]) begin
                w_on  = 1'b1;
                w_col = MOLE_COLOR;
            end
        end
    end

    // one-cycle registered pixel, blanked outside active video
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_on   <= 1'b0;
            mole_color <= TRANSPARENT;
        end else begin
            pixel_on   <= video_on && w_on;
            mole_color <= (video_on && w_on) ? w_col : TRANSPARENT;
        end
    end
endmodule

// File: tb/tb_mole_field_animator.sv
// tb_mole_field_animator: directed checks of spawn/whack/escape flow, sprite rendering and reset
module tb_mole_field_animator;
`ifdef MOLE_HIT_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif
    localparam logic [11:0] MC = 12'h642;
    localparam logic [11:0] TR = 12'hFFF;
    localparam logic [11:0] HC = 12'hF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [49:0] hole_x_flat = {10'd320, 10'd420, 10'd320, 10'd220, 10'd320};
    logic [49:0] hole_y_flat = {10'd320, 10'd220, 10'd220, 10'd220, 10'd120};
    logic        spawn_valid = 1'b0;
    logic [2:0]  spawn_hole = 3'd0;
    logic        spawn_ready;
    logic        whack_valid = 1'b0;
    logic [2:0]  whack_hole = 3'd0;
    logic        hit_pulse, miss_pulse, escape_pulse;
    logic [7:0]  hit_count;
    logic [4:0]  active_mask;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        video_on = 1'b1;
    logic        pixel_on;
    logic [11:0] mole_color;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int esc_cnt = 0;
    int pc0 = 0;

    mole_field_animator #(
        .NUM_HOLES(5), .STEP_CYCLES(4), .LEVELS(4), .HOLD_TICKS(2), .HIT_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .hole_x_flat(hole_x_flat), .hole_y_flat(hole_y_flat),
        .spawn_valid(spawn_valid), .spawn_hole(spawn_hole), .spawn_ready(spawn_ready),
        .whack_valid(whack_valid), .whack_hole(whack_hole),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .escape_pulse(escape_pulse),
        .hit_count(hit_count), .active_mask(active_mask),
        .x(x), .y(y), .video_on(video_on),
        .pixel_on(pixel_on), .mole_color(mole_color)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && (hit_pulse || miss_pulse || escape_pulse)) pulse_cnt <= pulse_cnt + 1;
        if (escape_pulse) esc_cnt <= esc_cnt + 1;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic eon, input logic [11:0] ecol, input string tag);
        x = px;
        y = py;
        @(negedge clk);
        chk({tag, "_on"}, 32'(pixel_on), 32'(eon));
        chk({tag, "_col"}, 32'(mole_color), 32'(ecol));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pixel_on", 32'(pixel_on), 0);
        chk("rst_color", 32'(mole_color), 32'(TR));
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_active", 32'(active_mask), 0);
        chk("rst_pulses", 32'({hit_pulse, miss_pulse, escape_pulse}), 0);
        chk("rst_ready", 32'(spawn_ready), 1);
        rst = 1'b0;
        spawn_valid = 1'b1;
        spawn_hole = 3'd2;
        #1 chk("spawn2_ready", 32'(spawn_ready), 1);
        at(1);
        spawn_valid = 1'b0;
        chk("rise_active", 32'(active_mask), 32'h04);
        at(2);
        probe(320, 224, 1, MC, "r0_vis");
        probe(320, 223, 0, TR, "r0_hid");
        at(5);
        probe(320, 220, 1, MC, "r1_vis");
        probe(320, 219, 0, TR, "r1_hid");
        at(9);
        probe(320, 216, 1, MC, "r2_vis");
        probe(320, 215, 0, TR, "r2_hid");
        at(13);
        probe(320, 212, 1, MC, "r3_top");
        probe(307, 220, 1, MC, "r3_wide");
        chk("r3_active", 32'(active_mask), 32'h04);
        at(17);
        probe(307, 220, 0, TR, "up_narrow");
        probe(315, 219, 1, 12'hFFF, "up_eye");
        probe(317, 220, 1, MC, "up_body");
        at(23);
        probe(307, 220, 0, TR, "up_last");
        probe(307, 220, 1, MC, "s3_wide");
        at(29);
        probe(320, 216, 1, MC, "s2_vis");
        probe(320, 215, 0, TR, "s2_hid");
        at(33);
        probe(320, 220, 1, MC, "s1_vis");
        probe(320, 219, 0, TR, "s1_hid");
        at(37);
        probe(320, 224, 1, MC, "s0_vis");
        probe(320, 223, 0, TR, "s0_hid");
        chk("esc_before", 32'(escape_pulse), 0);
        chk("sink_active", 32'(active_mask), 32'h04);
        @(negedge clk);
        chk("esc_pulse", 32'(escape_pulse), 1);
        chk("esc_active", 32'(active_mask), 0);
        @(negedge clk);
        chk("esc_after", 32'(escape_pulse), 0);
        spawn_valid = 1'b1;
        spawn_hole = 3'd0;
        at(42);
        spawn_valid = 1'b0;
        at(45);
        chk("esc_once", 32'(esc_cnt), 1);
        at(57);
        whack_valid = 1'b1;
        whack_hole = 3'd0;
        x = 320;
        y = 120;
        at(58);
        whack_valid = 1'b0;
        chk("hit_pulse", 32'(hit_pulse), 1);
        chk("hit_no_miss", 32'(miss_pulse), 0);
        chk("hit_count1", 32'(hit_count), 1);
        chk("pre_whack_px", 32'(mole_color), 32'(MC));
        at(59);
        chk("hit_pulse_end", 32'(hit_pulse), 0);
        chk("hit_px_on", 32'(pixel_on), 32'(FLASH));
        chk("hit_px_col", 32'(mole_color), 32'(FLASH ? HC : TR));
        chk("hit_active", 32'(active_mask), 32'(FLASH));
        at(60);
        whack_valid = 1'b1;
        at(61);
        whack_valid = 1'b0;
        chk("rewhack_miss", 32'(miss_pulse), 1);
        chk("rewhack_nohit", 32'(hit_pulse), 0);
        chk("rewhack_count", 32'(hit_count), 1);
        at(63);
        chk("flash_late_col", 32'(mole_color), 32'(FLASH ? HC : TR));
        chk("flash_late_act", 32'(active_mask), 32'(FLASH));
        at(64);
        chk("flash_end_col", 32'(mole_color), 32'(FLASH ? HC : TR));
        chk("flash_end_act", 32'(active_mask), 0);
        at(65);
        chk("flash_gone_on", 32'(pixel_on), 0);
        at(66);
        whack_valid = 1'b1;
        whack_hole = 3'd4;
        at(67);
        whack_hole = 3'd7;
        chk("miss_idle", 32'(miss_pulse), 1);
        chk("miss_nohit", 32'(hit_pulse), 0);
        chk("miss_count", 32'(hit_count), 1);
        at(68);
        whack_valid = 1'b0;
        chk("miss_oob", 32'(miss_pulse), 1);
        at(69);
        chk("miss_end", 32'(miss_pulse), 0);
        at(70);
        spawn_valid = 1'b1;
        spawn_hole = 3'd1;
        #1 chk("spawn1_ready", 32'(spawn_ready), 1);
        at(71);
        spawn_valid = 1'b0;
        chk("spawn1_active", 32'(active_mask), 32'h02);
        at(72);
        spawn_valid = 1'b1;
        #1 chk("busy_ready", 32'(spawn_ready), 0);
        at(73);
        spawn_valid = 1'b0;
        probe(220, 220, 1, MC, "no_respawn");
        chk("busy_active", 32'(active_mask), 32'h02);
        spawn_valid = 1'b1;
        spawn_hole = 3'd3;
        whack_valid = 1'b1;
        whack_hole = 3'd3;
        #1 chk("sw_ready", 32'(spawn_ready), 1);
        at(75);
        spawn_valid = 1'b0;
        whack_valid = 1'b0;
        chk("sw_miss", 32'(miss_pulse), 1);
        chk("sw_nohit", 32'(hit_pulse), 0);
        chk("sw_active", 32'(active_mask), 32'h0A);
        video_on = 1'b0;
        probe(300, 300, 0, TR, "vid_off_empty");
        probe(220, 220, 0, TR, "vid_off_mole");
        video_on = 1'b1;
        probe(220, 220, 1, MC, "vid_on_mole");
        at(79);
        spawn_valid = 1'b1;
        spawn_hole = 3'd2;
        at(80);
        spawn_valid = 1'b0;
        at(81);
        whack_valid = 1'b1;
        whack_hole = 3'd3;
        x = 320;
        y = 224;
        at(82);
        whack_valid = 1'b0;
        chk("pre_rst_hit", 32'(hit_pulse), 1);
        chk("pre_rst_count", 32'(hit_count), 2);
        chk("pre_rst_px", 32'(pixel_on), 1);
        rst = 1'b1;
        #1;
        chk("arst_px", 32'(pixel_on), 0);
        chk("arst_col", 32'(mole_color), 32'(TR));
        chk("arst_hit", 32'(hit_pulse), 0);
        chk("arst_count", 32'(hit_count), 0);
        chk("arst_active", 32'(active_mask), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pc0 = pulse_cnt;
        at(38);
        chk("post_active", 32'(active_mask), 0);
        probe(320, 224, 0, TR, "post_idle");
        chk("post_quiet", 32'(pulse_cnt), 32'(pc0));
        chk("post_count", 32'(hit_count), 0);
        at(40);
        spawn_valid = 1'b1;
        spawn_hole = 3'd2;
        #1 chk("post_ready", 32'(spawn_ready), 1);
        at(41);
        spawn_valid = 1'b0;
        at(43);
        probe(320, 220, 0, TR, "phase_lvl0");
        probe(320, 220, 1, MC, "phase_lvl1");
        chk("phase_active", 32'(active_mask), 32'h04);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
